handshake_fifo: RTL and testbench
=================================

Name: handshake_fifo

Overview:
- Elastic buffer with a valid-ready consumer port upstream and a valid-ready producer port downstream.
- Decouples the upstream ready from the downstream ready, so no combinational ready path crosses the block.
- Used between pipeline stages, e.g. dispatch→RS, FU→CDB arbiter.
- A thin wrapper (see Decomposition) binds the flat ports to the handshake_if consumer and producer modports.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, number of entries. Must be ≥2; need not be a power of 2. Elaboration-time $error if DEPTH<2.
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH. Must satisfy 1 ≤ AF_THRESH ≤ DEPTH.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all entries
- in_valid  input  1  upstream data valid
- in_ready  output  1  FIFO can accept this cycle
- in_data  input  DATA_WIDTH  upstream payload
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head
- out_data  output  DATA_WIDTH  head payload
- count  output  $clog2(DEPTH+1)  current occupancy
- almost_full  output  1  count ≥ AF_THRESH

Behaviour:
- Reset (async assert, sync release):
  - head=0, tail=0, count=0.
  - Hence out_valid=0, in_ready=1, almost_full=0 (AF_THRESH≥1), count=0.
  - out_data = mem[0]; storage contents are not reset; value is don't-care while out_valid=0.
- Transfer events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Output decode, all from registered state only:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[head].
  - almost_full = (count ≥ AF_THRESH).
- No output depends combinationally on in_valid or out_ready.
- Push: mem[tail] ← in_data; tail advances.
- Pop: head advances.
- Pointer advance: ptr = (ptr==DEPTH-1) ? 0 : ptr+1. Explicit wrap for non-power-of-2 DEPTH.
- Count update: count += push − pop.
  - Simultaneous push & pop leaves count unchanged.
  - Both pointers still advance.
- Latency: data pushed in cycle N appears with out_valid=1 in cycle N+1. There is no empty-bypass path. Minimum latency is 1 cycle.
- Throughput: 1 transfer/cycle sustained whenever 0<count<DEPTH.
- Full: in_ready=0, even if out_ready=1 that cycle; a pop frees a slot for the next cycle. in_data is ignored.
- Empty: out_valid=0; out_ready is ignored; count never underflows.
- Producer rules (downstream side):
  - Once out_valid=1, out_valid and out_data stay stable until pop or flush.
  - Entries leave in strict FIFO order.
- Consumer rules (upstream side): correctness must not rely on upstream holding in_valid/in_data stable. Each cycle's push is sampled independently.
- Flush:
  - Next cycle head=tail=0, count=0.
  - A push or pop presented in the flush cycle is discarded/ignored.
  - flush has priority over push/pop.
- Reset mid-operation: all in-flight entries are lost immediately; outputs take reset values asynchronously.
- Assertions (sim only):
  - count ≤ DEPTH.
  - No push when count==DEPTH.
  - out_data stable while out_valid & !out_ready & !flush.

Decomposition:
- handshake_pkg:
  - function ptr_width(depth) = (depth>1)?$clog2(depth):1.
  - function cnt_width(depth) = $clog2(depth+1).
  - typedef for the wrap-increment helper function.
- Core is a single module; no sub-module is needed for storage (inferred register array).
- Separate thin wrapper handshake_fifo_if: takes handshake_if.consumer and handshake_if.producer ports and instantiates handshake_fifo.

Test Plan:
- Reset then idle: after rst deasserts → out_valid=0, in_ready=1, count=0, almost_full=0 for 10 cycles with in_valid=0.
- DEPTH=4, out_ready=0, push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles →
  - count 1,2,3,4.
  - almost_full rises at count=3.
  - in_ready=0 at count=4.
  - A fifth push of 0xA5 is not accepted.
- Continuing from full: out_ready=1 for 4 cycles → out_data 0xA1..0xA4 in order; count 3,2,1,0; in_ready returns to 1 the cycle after the first pop.
- Streaming DEPTH=3 (non-power-of-2): in_valid=1 and out_ready=1 continuously for 20 words 0..19 →
  - Exactly 1-cycle latency.
  - Output sequence 0..19.
  - Count steady at 1.
  - Pointers wrap 2→0 correctly.
- Random in_valid/out_ready (50%) for 1000 cycles versus a scoreboard queue →
  - No loss, duplication or reordering.
  - out_data held stable under backpressure.
- Flush with count=2 and simultaneous push → next cycle count=0, out_valid=0, pushed word absent. Async rst pulse mid-stream → immediate out_valid=0, count=0.

Source files
------------

// File: rtl/handshake_pkg.sv
// Sizing helpers and pointer-wrap arithmetic shared by the handshake FIFO family.
package handshake_pkg;

    typedef int unsigned idx_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so the entry count need not be a power of two.
    function automatic idx_t wrap_inc(input idx_t ptr, input idx_t depth);
        return (ptr == depth - 1) ? '0 : ptr + 1;
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Single valid/ready channel carrying a DATA_WIDTH payload.
// A beat transfers on a rising edge where valid & ready are both high; once valid
// is raised, the sender holds valid and data stable until that transfer happens.
interface handshake_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport consumer (input valid, input data, output ready);
    modport producer (output valid, output data, input ready);
endinterface

// File: rtl/handshake_fifo_if.sv
// Binds the flat handshake_fifo ports onto consumer/producer handshake_if modports.
module handshake_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    handshake_if.consumer              up,
    handshake_if.producer              dn,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    handshake_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF_THRESH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (up.valid),
        .in_ready    (up.ready),
        .in_data     (up.data),
        .out_valid   (dn.valid),
        .out_ready   (dn.ready),
        .out_data    (dn.data),
        .count       (count),
        .almost_full (almost_full)
    );

endmodule

// File: rtl/handshake_fifo.sv
// Elastic FIFO between two valid/ready ports; every output decodes from registered
// state so no combinational path runs from out_ready to in_ready.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);

    if (DEPTH < 2) begin : g_depth_chk
        $error("handshake_fifo: DEPTH must be >= 2 (got %0d)", DEPTH);
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_af_chk
        $error("handshake_fifo: AF_THRESH must be within 1..DEPTH (got %0d)", AF_THRESH);
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push;
    logic                  pop;

    assign in_ready    = (count_q != FULL_C);
    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[head_q];
    assign almost_full = (count_q >= AF_C);
    assign count       = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Flush wins over any transfer presented in the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = PW'(wrap_inc(idx_t'(tail_q), idx_t'(DEPTH)));
            end
            if (pop) begin
                head_d = PW'(wrap_inc(idx_t'(head_q), idx_t'(DEPTH)));
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; its contents only matter while out_valid is high.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[tail_q] <= in_data;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= FULL_C);

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == FULL_C)));

    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule

// File: tb/tb_handshake_fifo.sv
// Bench for handshake_fifo: a DEPTH=4 and a DEPTH=3 instance, each shadowed by a
// queue-based reference model whose contents are the expected FIFO order.
module tb_handshake_fifo;

    localparam int DW = 32;
    localparam int DA = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [2:0]    a_count;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_count;

    handshake_fifo #(.DATA_WIDTH(DW), .DEPTH(DA), .AF_THRESH(DA - 1)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .almost_full(a_af)
    );

    handshake_fifo #(.DATA_WIDTH(DW), .DEPTH(DB), .AF_THRESH(DB - 1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .almost_full(b_af)
    );

    int            n_vec = 0;
    int            n_mis = 0;
    logic [DW-1:0] a_exp_q[$];
    logic [DW-1:0] b_exp_q[$];
    logic [DW-1:0] b_seen[$];
    bit            b_record = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        a_in_valid = v; a_in_data = d; a_out_ready = r; a_flush = f;
    endtask

    task automatic set_b(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        b_in_valid = v; b_in_data = d; b_out_ready = r; b_flush = f;
    endtask

    // Monitor + model for instance A: compare outputs, then advance the model.
    always @(negedge clk) begin
        int lvl;
        if (rst) begin
            chk("a_rst_out_valid", DW'(a_out_valid), '0);
            chk("a_rst_in_ready", DW'(a_in_ready), DW'(1));
            chk("a_rst_count", DW'(a_count), '0);
            chk("a_rst_almost_full", DW'(a_af), '0);
            a_exp_q.delete();
        end else begin
            lvl = a_exp_q.size();
            chk("a_count", DW'(a_count), DW'(lvl));
            chk("a_in_ready", DW'(a_in_ready), DW'(lvl != DA));
            chk("a_out_valid", DW'(a_out_valid), DW'(lvl != 0));
            chk("a_almost_full", DW'(a_af), DW'(lvl >= DA - 1));
            if (lvl != 0) chk("a_out_data", a_out_data, a_exp_q[0]);
            if (a_flush) begin
                a_exp_q.delete();
            end else begin
                if (lvl != 0 && a_out_ready) void'(a_exp_q.pop_front());
                if (a_in_valid && lvl != DA) a_exp_q.push_back(a_in_data);
            end
        end
    end

    // Monitor + model for instance B.
    always @(negedge clk) begin
        int lvl;
        if (rst) begin
            chk("b_rst_out_valid", DW'(b_out_valid), '0);
            chk("b_rst_in_ready", DW'(b_in_ready), DW'(1));
            chk("b_rst_count", DW'(b_count), '0);
            chk("b_rst_almost_full", DW'(b_af), '0);
            b_exp_q.delete();
        end else begin
            lvl = b_exp_q.size();
            chk("b_count", DW'(b_count), DW'(lvl));
            chk("b_in_ready", DW'(b_in_ready), DW'(lvl != DB));
            chk("b_out_valid", DW'(b_out_valid), DW'(lvl != 0));
            chk("b_almost_full", DW'(b_af), DW'(lvl >= DB - 1));
            if (lvl != 0) chk("b_out_data", b_out_data, b_exp_q[0]);
            if (b_record && b_out_valid && b_out_ready) b_seen.push_back(b_out_data);
            if (b_flush) begin
                b_exp_q.delete();
            end else begin
                if (lvl != 0 && b_out_ready) void'(b_exp_q.pop_front());
                if (b_in_valid && lvl != DB) b_exp_q.push_back(b_in_data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_a(0, '0, 0, 0);
        set_b(0, '0, 0, 0);
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset.
        repeat (10) step();

        // Fill A to full, then one extra push that must be refused.
        for (int i = 0; i < 4; i++) begin
            set_a(1, DW'(32'hA1 + i), 0, 0);
            step();
        end
        set_a(1, DW'(32'hA5), 0, 0);
        step();

        // Drain A in order.
        for (int i = 0; i < 4; i++) begin
            set_a(0, '0, 1, 0);
            step();
        end
        set_a(0, '0, 0, 0);
        step();

        // Continuous streaming through the DEPTH=3 instance.
        b_record = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_b(1, DW'(i), 1, 0);
            step();
        end
        set_b(0, '0, 1, 0);
        repeat (3) step();
        b_record = 1'b0;
        chk("b_stream_len", DW'(b_seen.size()), DW'(20));
        for (int i = 0; i < 20; i++) begin
            if (i < b_seen.size()) chk("b_stream_word", b_seen[i], DW'(i));
        end
        set_b(0, '0, 0, 0);

        // Flush with two entries held and a push presented in the same cycle.
        set_a(1, DW'(32'h11), 0, 0); step();
        set_a(1, DW'(32'h22), 0, 0); step();
        set_a(1, DW'(32'hEE), 0, 1); step();
        set_a(0, '0, 0, 0);          step();
        set_a(1, DW'(32'h33), 0, 0); step();
        set_a(0, '0, 1, 0);          step();
        set_a(0, '0, 0, 0);          step();

        // Random traffic on both instances, occasional flush on A.
        for (int i = 0; i < 1000; i++) begin
            set_a(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 63) == 0));
            set_b(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            step();
        end

        // Asynchronous reset pulse mid-stream.
        set_a(1, $urandom, 0, 0);
        set_b(1, $urandom, 0, 0);
        repeat (2) step();
        set_a(0, '0, 0, 0);
        set_b(0, '0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("a_async_rst_out_valid", DW'(a_out_valid), '0);
        chk("a_async_rst_count", DW'(a_count), '0);
        chk("a_async_rst_in_ready", DW'(a_in_ready), DW'(1));
        chk("b_async_rst_out_valid", DW'(b_out_valid), '0);
        chk("b_async_rst_count", DW'(b_count), '0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Post-reset traffic and drain.
        step();
        for (int i = 0; i < 40; i++) begin
            set_a(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            set_b(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            step();
        end
        set_a(0, '0, 1, 0);
        set_b(0, '0, 1, 0);
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
